sram_2mx8_wb_bridge: RTL and testbench

Wishbone slave converting 32-bit Amber bus accesses into byte-serial cycles on the external 2Mx8 asynchronous SRAM bank (4 chips, 8 MB total). Sits inside `system`, directly upstream of the board SRAM pins.
- It drives the active-high chip selects and strobes that the top level inverts onto `o_sram_cs_n`, `o_sram_read_n` and `o_sram_write_n`.
- It owns the `io_sram_data` tristate.

---
 rtl/sram_2mx8_wb_bridge_pkg.sv | 41 ++++
 rtl/sram_2mx8_wb_bridge.sv | 177 +++++++++++++++++
 tb/tb_sram_2mx8_wb_bridge.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_2mx8_wb_bridge_pkg.sv
// Shared constants, state encoding and small helpers for the 2Mx8 SRAM Wishbone bridge.
package sram_2mx8_wb_bridge_pkg;

    localparam int SRAM_AW  = 21;
    localparam int SRAM_NCS = 4;
    localparam int CS_LSB   = 21;
    localparam int CS_MSB   = 22;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RD_STROBE = 3'd1;
    localparam logic [2:0] ST_WR_SETUP  = 3'd2;
    localparam logic [2:0] ST_WR_STROBE = 3'd3;
    localparam logic [2:0] ST_WR_HOLD   = 3'd4;
    localparam logic [2:0] ST_NEXT      = 3'd5;
    localparam logic [2:0] ST_ACK       = 3'd6;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        RD_STROBE = ST_RD_STROBE,
        WR_SETUP  = ST_WR_SETUP,
        WR_STROBE = ST_WR_STROBE,
        WR_HOLD   = ST_WR_HOLD,
        NEXT      = ST_NEXT,
        ACK       = ST_ACK
    } state_t;

    // Lowest enabled lane at or above start; bit 2 flags that one exists.
    function automatic logic [2:0] first_lane(input logic [3:0] sel, input logic [2:0] start);
        logic [2:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (3'(i) >= start && sel[i]) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    function automatic logic [SRAM_NCS-1:0] cs_decode(input logic [1:0] f);
        return 4'b0001 << f;
    endfunction

endpackage

// File: rtl/sram_2mx8_wb_bridge.sv
// Wishbone slave that splits 32-bit accesses into byte-serial cycles on a 4-chip 2Mx8 async SRAM bank.
module sram_2mx8_wb_bridge
    import sram_2mx8_wb_bridge_pkg::*;
#(
    parameter int WAIT_CYC = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [31:0]         i_wb_adr,
    input  logic [3:0]          i_wb_sel,
    input  logic                i_wb_we,
    input  logic [31:0]         i_wb_dat,
    output logic [31:0]         o_wb_dat,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    output logic                o_wb_ack,
    output logic                o_wb_err,
    output logic [SRAM_NCS-1:0] o_sram_cs,
    output logic                o_sram_read,
    output logic                o_sram_write,
    output logic [SRAM_AW-1:0]  o_sram_addr,
    inout  logic [7:0]          io_sram_data
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

    state_t      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_cap_q, rd_cap_d;
    logic        abort_q, abort_d;
    logic [1:0]  csel_q, csel_d;
    logic [18:0] wadr_q, wadr_d;
    logic [3:0]  sel_q;
    logic        we_q;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rbuf_q;
    logic        data_oe;
    logic [7:0]  wd_q;
    logic        req, accept, byte_d, oe_d;
    logic [2:0]  fl;
    logic        unused_adr;

    assign req        = i_wb_cyc & i_wb_stb;
    assign accept     = (state_q == IDLE) && req;
    assign o_wb_err   = 1'b0;
    assign unused_adr = &{1'b0, i_wb_adr[31:23], i_wb_adr[1:0]};

    assign io_sram_data = data_oe ? wd_q : 8'hzz;

    // Request fields as seen by the output registers on the acceptance edge.
    always_comb begin
        csel_d = csel_q;
        wadr_d = wadr_q;
        wdat_d = wdat_q;
        if (accept) begin
            csel_d = i_wb_adr[CS_MSB:CS_LSB];
            wadr_d = i_wb_adr[20:2];
            wdat_d = i_wb_dat;
        end
    end

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        cnt_d    = cnt_q;
        rd_cap_d = rd_cap_q;
        abort_d  = abort_q;
        fl       = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    abort_d = 1'b0;
                    fl      = first_lane(i_wb_sel, 3'd0);
                    if (!fl[2]) begin
                        state_d = ACK;
                    end else begin
                        lane_d   = fl[1:0];
                        cnt_d    = CNT_LOAD;
                        rd_cap_d = 1'b0;
                        state_d  = i_wb_we ? WR_SETUP : RD_STROBE;
                    end
                end
            end
            // Counter covers the strobe-active cycles; one extra capture cycle follows.
            RD_STROBE: begin
                if (cnt_q != 4'd0)  cnt_d    = cnt_q - 4'd1;
                else if (!rd_cap_q) rd_cap_d = 1'b1;
                else                state_d  = NEXT;
            end
            WR_SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = WR_STROBE;
            end
            WR_STROBE: begin
                if (cnt_q != 4'd0) cnt_d   = cnt_q - 4'd1;
                else               state_d = WR_HOLD;
            end
            WR_HOLD: state_d = NEXT;
            NEXT: begin
                fl = first_lane(sel_q, {1'b0, lane_q} + 3'd1);
                if (abort_q || !req) begin
                    state_d = IDLE;
                end else if (fl[2]) begin
                    lane_d   = fl[1:0];
                    cnt_d    = CNT_LOAD;
                    rd_cap_d = 1'b0;
                    state_d  = we_q ? WR_SETUP : RD_STROBE;
                end else begin
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A drop anywhere in the transfer is remembered until the byte boundary.
        if (state_q != IDLE && !req) abort_d = 1'b1;
    end

    assign byte_d = (state_d == RD_STROBE) || (state_d == WR_SETUP) ||
                    (state_d == WR_STROBE) || (state_d == WR_HOLD);
    assign oe_d   = (state_d == WR_SETUP) || (state_d == WR_STROBE) || (state_d == WR_HOLD);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            cnt_q        <= '0;
            rd_cap_q     <= 1'b0;
            abort_q      <= 1'b0;
            csel_q       <= '0;
            wadr_q       <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            wdat_q       <= '0;
            rbuf_q       <= '0;
            o_sram_cs    <= '0;
            o_sram_read  <= 1'b0;
            o_sram_write <= 1'b0;
            o_sram_addr  <= '0;
            data_oe      <= 1'b0;
            wd_q         <= '0;
            o_wb_ack     <= 1'b0;
            o_wb_dat     <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            cnt_q    <= cnt_d;
            rd_cap_q <= rd_cap_d;
            abort_q  <= abort_d;
            csel_q   <= csel_d;
            wadr_q   <= wadr_d;
            wdat_q   <= wdat_d;
            if (accept) begin
                sel_q  <= i_wb_sel;
                we_q   <= i_wb_we;
                rbuf_q <= '0;
            end
            if (state_q == RD_STROBE && state_d == NEXT)
                rbuf_q[{lane_q, 3'b000} +: 8] <= io_sram_data;
            if (state_q == NEXT && state_d == ACK && !we_q)
                o_wb_dat <= rbuf_q;

            // Pins are decoded from the next state so they change together with it.
            o_sram_cs    <= byte_d ? cs_decode(csel_d) : '0;
            o_sram_read  <= (state_d == RD_STROBE);
            o_sram_write <= (state_d == WR_STROBE);
            data_oe      <= oe_d;
            o_wb_ack     <= (state_d == ACK);
            if (byte_d) begin
                o_sram_addr <= {wadr_d, lane_d};
                wd_q        <= wdat_d[{lane_d, 3'b000} +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_2mx8_wb_bridge.sv
// Directed bench for sram_2mx8_wb_bridge: vector table plus reset/abort sequences against a byte SRAM model.
module tb_sram_2mx8_wb_bridge;

    localparam int W = 2;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_wb_adr = '0;
    logic [3:0]  i_wb_sel = '0;
    logic        i_wb_we = 1'b0;
    logic [31:0] i_wb_dat = '0;
    logic [31:0] o_wb_dat;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic        o_wb_ack, o_wb_err;
    logic [3:0]  o_sram_cs;
    logic        o_sram_read, o_sram_write;
    logic [20:0] o_sram_addr;
    wire  [7:0]  io_sram_data;

    sram_2mx8_wb_bridge #(.WAIT_CYC(W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel),
        .i_wb_we(i_wb_we), .i_wb_dat(i_wb_dat), .o_wb_dat(o_wb_dat),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
        .o_sram_cs(o_sram_cs), .o_sram_read(o_sram_read), .o_sram_write(o_sram_write),
        .o_sram_addr(o_sram_addr), .io_sram_data(io_sram_data)
    );

    always #5 i_clk = ~i_clk;

    // SRAM model: unwritten locations read 8'h5A
    logic [7:0] mem [logic [22:0]];
    logic [7:0] rd_byte = 8'h5A;
    logic       tb_drv = 1'b0;

    function automatic logic [1:0] cs_idx(input logic [3:0] cs);
        case (cs)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    always @(o_sram_cs or o_sram_addr or o_sram_read) begin
        if (mem.exists({cs_idx(o_sram_cs), o_sram_addr})) rd_byte = mem[{cs_idx(o_sram_cs), o_sram_addr}];
        else rd_byte = 8'h5A;
    end

    assign io_sram_data = tb_drv ? 8'h00 : ((o_sram_read && (o_sram_cs != 4'b0)) ? rd_byte : 8'hzz);

    typedef struct {
        logic [20:0] addr;
        logic [7:0]  data;
        int          len;
    } wlog_t;
    wlog_t wlog[$];

    int         viol = 0;
    logic [3:0] prev_cs = '0;
    logic [20:0] prev_addr = '0;
    logic       prev_wr = 1'b0;

    always @(negedge i_clk) begin
        if (o_sram_read && o_sram_write) viol++;
        if (o_sram_read && io_sram_data !== rd_byte) viol++;
        if (o_sram_cs != 4'b0 && prev_cs != 4'b0 && o_sram_addr != prev_addr) viol++;
        if (o_sram_write && !prev_wr && (o_sram_cs != prev_cs || o_sram_addr != prev_addr)) viol++;
        if (o_sram_write && o_sram_cs == 4'b0) viol++;
        if (o_sram_write === 1'b1) begin
            mem[{cs_idx(o_sram_cs), o_sram_addr}] = io_sram_data;
            if (!prev_wr) wlog.push_back('{addr: o_sram_addr, data: io_sram_data, len: 1});
            else if (wlog.size() > 0) wlog[wlog.size()-1].len++;
        end
        prev_cs   = o_sram_cs;
        prev_addr = o_sram_addr;
        prev_wr   = (o_sram_write === 1'b1);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request from a negedge; returns edges from acceptance to ack (-1 on timeout).
    task automatic do_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] wd, output int lat, output logic [3:0] cs_or);
        wlog.delete();
        cs_or = '0;
        lat   = -1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
        i_wb_adr = adr;  i_wb_sel = sel;  i_wb_dat = wd;
        for (int n = 1; n <= 300; n++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            cs_or |= o_sram_cs;
            if (o_wb_ack) begin
                lat = n;
                break;
            end
        end
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic [31:0] exp_dat;
        int          exp_lat;
        logic [3:0]  exp_cs;
        int          exp_nstb;
        logic [20:0] a0;
        logic [7:0]  d0;
        logic [20:0] al;
        logic [7:0]  dl;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int         lat, badlen, rd1, extra;
        logic [3:0] cs_or;
        logic       found, ack_seen;

        vecs[0] = '{"wr_full",   1'b1, 32'h0012_3454, 4'hF, 32'hDEADBEEF, 32'h0000_0000, 4*(W+3)+1, 4'b0001, 4, 21'h123454, 8'hEF, 21'h123457, 8'hDE};
        vecs[1] = '{"rd_full",   1'b0, 32'h0012_3454, 4'hF, 32'h0,        32'hDEADBEEF, 4*(W+2)+1, 4'b0001, 0, 21'h0, 8'h0, 21'h0, 8'h0};
        vecs[2] = '{"rd_chip3",  1'b0, 32'h0060_0000, 4'hF, 32'h0,        32'h5A5A5A5A, 4*(W+2)+1, 4'b1000, 0, 21'h0, 8'h0, 21'h0, 8'h0};
        vecs[3] = '{"wr_sparse", 1'b1, 32'h0000_0100, 4'hA, 32'h11223344, 32'h5A5A5A5A, 2*(W+3)+1, 4'b0001, 2, 21'h000101, 8'h33, 21'h000103, 8'h11};
        vecs[4] = '{"rd_sparse", 1'b0, 32'h0000_0100, 4'hF, 32'h0,        32'h115A335A, 4*(W+2)+1, 4'b0001, 0, 21'h0, 8'h0, 21'h0, 8'h0};
        vecs[5] = '{"rd_lane1",  1'b0, 32'h0000_0100, 4'h2, 32'h0,        32'h00003300, 1*(W+2)+1, 4'b0001, 0, 21'h0, 8'h0, 21'h0, 8'h0};
        vecs[6] = '{"wr_sel0",   1'b1, 32'h0000_0100, 4'h0, 32'hFFFFFFFF, 32'h00003300, 1,         4'b0000, 0, 21'h0, 8'h0, 21'h0, 8'h0};

        // Reset state; TB drives 8'h00 so any DUT drive would show up on the bus
        tb_drv = 1'b1;
        @(posedge i_clk); #1;
        check("rst_cs",   32'(o_sram_cs), 32'h0);
        check("rst_read", 32'(o_sram_read), 32'h0);
        check("rst_write",32'(o_sram_write), 32'h0);
        check("rst_addr", 32'(o_sram_addr), 32'h0);
        check("rst_ack",  32'(o_wb_ack), 32'h0);
        check("rst_dat",  o_wb_dat, 32'h0);
        check("rst_bus",  32'(io_sram_data), 32'h0);
        check("err_tie",  32'(o_wb_err), 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0; tb_drv = 1'b0;
        @(negedge i_clk);

        foreach (vecs[i]) begin
            do_xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdat, lat, cs_or);
            check({vecs[i].name, "_lat"},  32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_cs"},   32'(cs_or), 32'(vecs[i].exp_cs));
            check({vecs[i].name, "_dat"},  o_wb_dat, vecs[i].exp_dat);
            check({vecs[i].name, "_nstb"}, 32'(wlog.size()), 32'(vecs[i].exp_nstb));
            if (vecs[i].exp_nstb > 0 && wlog.size() > 0) begin
                badlen = 0;
                foreach (wlog[j]) if (wlog[j].len != W) badlen++;
                check({vecs[i].name, "_stblen"}, 32'(badlen), 32'h0);
                check({vecs[i].name, "_a0"}, 32'(wlog[0].addr), 32'(vecs[i].a0));
                check({vecs[i].name, "_d0"}, 32'(wlog[0].data), 32'(vecs[i].d0));
                check({vecs[i].name, "_al"}, 32'(wlog[wlog.size()-1].addr), 32'(vecs[i].al));
                check({vecs[i].name, "_dl"}, 32'(wlog[wlog.size()-1].data), 32'(vecs[i].dl));
            end
        end

        // Abort: drop stb during the read of byte 1
        found = 1'b0; ack_seen = 1'b0; rd1 = 0; extra = 0;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
        i_wb_adr = 32'h0012_3454; i_wb_sel = 4'hF;
        for (int n = 0; n < 100; n++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_wb_ack) ack_seen = 1'b1;
            if (o_sram_read && o_sram_addr[1:0] == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_reach_b1", 32'(found), 32'h1);
        rd1 = 1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_wb_ack) ack_seen = 1'b1;
            if (o_sram_read && o_sram_addr[1:0] == 2'd1) rd1++;
            if (o_sram_cs != 4'b0 && o_sram_addr[1:0] != 2'd1) extra++;
        end
        check("abort_no_ack", 32'(ack_seen), 32'h0);
        check("abort_b1_len", 32'(rd1), 32'(W + 1));
        check("abort_no_more", 32'(extra), 32'h0);
        check("abort_dat_hold", o_wb_dat, 32'h00003300);

        do_xfer(1'b0, 32'h0012_3454, 4'hF, 32'h0, lat, cs_or);
        check("post_abort_lat", 32'(lat), 32'(4*(W+2)+1));
        check("post_abort_dat", o_wb_dat, 32'hDEADBEEF);

        // Reset during the write strobe of byte 2
        found = 1'b0;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
        i_wb_adr = 32'h0000_0200; i_wb_sel = 4'hF; i_wb_dat = 32'hCAFEF00D;
        for (int n = 0; n < 100; n++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_sram_write && o_sram_addr[1:0] == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("rstmid_reach_b2", 32'(found), 32'h1);
        i_rst = 1'b1; i_wb_cyc = 1'b0; i_wb_stb = 1'b0; tb_drv = 1'b1;
        @(posedge i_clk); #1;
        check("rstmid_write", 32'(o_sram_write), 32'h0);
        check("rstmid_read",  32'(o_sram_read), 32'h0);
        check("rstmid_cs",    32'(o_sram_cs), 32'h0);
        check("rstmid_ack",   32'(o_wb_ack), 32'h0);
        check("rstmid_bus",   32'(io_sram_data), 32'h0);
        check("rstmid_dat",   o_wb_dat, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0; tb_drv = 1'b0;
        @(negedge i_clk);

        do_xfer(1'b0, 32'h0000_0200, 4'h3, 32'h0, lat, cs_or);
        check("post_rst_lat", 32'(lat), 32'(2*(W+2)+1));
        check("post_rst_dat", o_wb_dat, 32'h0000F00D);

        check("bus_protocol_viol", 32'(viol), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
